// File: rtl/ntt_coef_bank_if.sv
// Bundle between ntt_coef_bank and its neighbours: core run control, core BRAM
// ports A (read) and B (write), and the host load/unload coefficient streams.
interface ntt_coef_bank_if #(
  parameter int WIDTH = 23,
  parameter int WORDS = 64
);
  localparam int AW = $clog2(WORDS);
  localparam int DW = 4 * (WIDTH + 10);

  logic             go;
  logic [2:0]       mode_i;
  logic [2:0]       mode;
  logic             start;
  logic             done;
  logic             busy;
  logic [AW-1:0]    addra1;
  logic [DW-1:0]    doa1;
  logic             web1;
  logic [AW-1:0]    addrb1;
  logic [DW-1:0]    dib1;
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data;
  logic             ul_start;
  logic             ul_valid;
  logic             ul_ready;
  logic [WIDTH-1:0] ul_data;
  logic             ul_last;

  // master is the host/core side, slave is the coefficient bank itself
  modport master (
    output go, mode_i, done, addra1, web1, addrb1, dib1,
           ld_valid, ld_data, ul_start, ul_ready,
    input  mode, start, busy, doa1, ld_ready, ul_valid, ul_data, ul_last
  );

  modport slave (
    input  go, mode_i, done, addra1, web1, addrb1, dib1,
           ld_valid, ld_data, ul_start, ul_ready,
    output mode, start, busy, doa1, ld_ready, ul_valid, ul_data, ul_last
  );
endinterface

// File: rtl/ntt_coef_bank.sv
// Coefficient bank behind the NTT/INTT core's BRAM port, with host load/unload streams.
// Optional COEF_REDUCE_EN: unloaded values in [Q, 2^WIDTH) are reduced by Q (parameter Q exists only then).
module ntt_coef_bank #(
  parameter int WIDTH = 23,
`ifdef COEF_REDUCE_EN
  parameter logic [WIDTH-1:0] Q = 23'd8380417,
`endif
  parameter int WORDS = 64
) (
  input logic            clk,
  input logic            rst_n,
  ntt_coef_bank_if.slave bus
);

  localparam int AW = $clog2(WORDS);
  localparam int LW = WIDTH + 10;
  localparam int DW = 4 * LW;
  localparam int CW = AW + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    UL_RD,
    UL_OUT
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [DW-1:0]     mem [WORDS];

  logic [2:0]        mode_q;
  logic              start_q;
  logic [DW-1:0]     doa_q;

  logic [CW-1:0]     ld_cnt;
  logic [3*LW-1:0]   asm_q;
  logic [LW-1:0]     ld_lane;
  logic              ld_fire;
  logic              ld_word_done;

  logic [AW-1:0]     ul_addr;
  logic [1:0]        ul_lane;
  logic [WIDTH-1:0]  ul_coef [4];
  logic [WIDTH-1:0]  cur_coef;
  logic              ul_fire;

  logic              run_go;
  logic              ul_go;

  assign ld_lane      = {1'b0, bus.ld_data, 9'd0};
  assign ld_fire      = (state == LOAD) && bus.ld_valid;
  assign ld_word_done = ld_fire && (ld_cnt[1:0] == 2'd3);
  assign ul_fire      = (state == UL_OUT) && bus.ul_ready;
  assign run_go       = (state == IDLE) && !bus.ld_valid && bus.go;
  assign ul_go        = (state == IDLE) && !bus.ld_valid && !bus.go && bus.ul_start;
  assign cur_coef     = ul_coef[ul_lane];

  assign bus.mode  = mode_q;
  assign bus.start = start_q;
  assign bus.doa1  = doa_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // done is ignored during the start cycle so a level-style done left over
  // from the previous run cannot end the new run before the core has seen start
  always_comb begin
    next_state   = state;
    bus.busy     = (state != IDLE);
    bus.ld_ready = (state == LOAD);
    bus.ul_valid = (state == UL_OUT);
    bus.ul_last  = (state == UL_OUT) && (ul_lane == 2'd3) && (ul_addr == AW'(WORDS - 1));
`ifdef COEF_REDUCE_EN
    bus.ul_data  = (cur_coef >= Q) ? (cur_coef - Q) : cur_coef;
`else
    bus.ul_data  = cur_coef;
`endif
    case (state)
      IDLE: begin
        if (bus.ld_valid) begin
          next_state = LOAD;
        end else if (bus.go) begin
          next_state = RUN;
        end else if (bus.ul_start) begin
          next_state = UL_RD;
        end
      end
      LOAD: begin
        if (ld_fire && (ld_cnt == '1)) begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (bus.done && !start_q) begin
          next_state = IDLE;
        end
      end
      UL_RD: begin
        next_state = UL_OUT;
      end
      UL_OUT: begin
        if (ul_fire && (ul_lane == 2'd3)) begin
          next_state = (ul_addr == AW'(WORDS - 1)) ? IDLE : UL_RD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Run control, load assembly and unload pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 3'd0;
      start_q <= 1'b0;
      ld_cnt  <= '0;
      asm_q   <= '0;
      ul_addr <= '0;
      ul_lane <= 2'd0;
    end else begin
      start_q <= run_go;
      if (run_go) begin
        mode_q <= bus.mode_i;
      end
      if (ld_fire) begin
        ld_cnt <= ld_cnt + CW'(1);
        asm_q  <= {ld_lane, asm_q[3*LW-1:LW]};
      end
      if (ul_go) begin
        ul_addr <= '0;
        ul_lane <= 2'd0;
      end else if (ul_fire) begin
        ul_lane <= ul_lane + 2'd1;
        if (ul_lane == 2'd3) begin
          ul_addr <= ul_addr + AW'(1);
        end
      end
    end
  end

  // Memory is not reset; LOAD and RUN never overlap so the two writers are exclusive
  always_ff @(posedge clk) begin
    if (ld_word_done) begin
      mem[ld_cnt[CW-1:2]] <= {ld_lane, asm_q};
    end else if ((state == RUN) && bus.web1) begin
      mem[bus.addrb1] <= bus.dib1;
    end
  end

  // Read ports: the core read is registered (read-before-write), the unload read latches a word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doa_q <= '0;
      for (int k = 0; k < 4; k++) begin
        ul_coef[k] <= '0;
      end
    end else begin
      if (state == RUN) begin
        doa_q <= mem[bus.addra1];
      end
      if (state == UL_RD) begin
        for (int k = 0; k < 4; k++) begin
          ul_coef[k] <= mem[ul_addr][k*LW+9 +: WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_coef_bank.sv
// Directed self-checking bench for ntt_coef_bank: load, unload, core run,
// priority, mid-load reset and the optional COEF_REDUCE_EN correction.
module tb_ntt_coef_bank;

  localparam logic [131:0] WORD0 = {1'b0, 23'd3, 9'd0, 1'b0, 23'd2, 9'd0,
                                    1'b0, 23'd1, 9'd0, 1'b0, 23'd0, 9'd0};

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [131:0] model_mem [64];
  logic [22:0]  got [256];

  ntt_coef_bank_if bus ();

  ntt_coef_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected unload value of coefficient b from the bench's own memory model
  function automatic logic [22:0] exp_coef(input int b);
    logic [131:0] w;
    logic [22:0]  v;
    w = model_mem[b / 4];
    v = w[33 * (b % 4) + 9 +: 23];
`ifdef COEF_REDUCE_EN
    if (v >= 23'd8380417) v = v - 23'd8380417;
`endif
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.start !== 1'b0)    begin failures++; $display("[TB] FAIL reset_start got %b want 0", bus.start); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ld_ready got %b want 0", bus.ld_ready); end
    checks++; if (bus.ul_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_ul_valid got %b want 0", bus.ul_valid); end
    checks++; if (bus.ul_last !== 1'b0)  begin failures++; $display("[TB] FAIL reset_ul_last got %b want 0", bus.ul_last); end
    checks++; if (bus.ul_data !== 23'd0) begin failures++; $display("[TB] FAIL reset_ul_data got %0h want 0", bus.ul_data); end
    checks++; if (bus.doa1 !== 132'd0)   begin failures++; $display("[TB] FAIL reset_doa1 got %0h want 0", bus.doa1); end
    checks++; if (bus.mode !== 3'd0)     begin failures++; $display("[TB] FAIL reset_mode got %0d want 0", bus.mode); end
    rst_n = 1'b1;
    tick();
  endtask

  // Streams base+i for i = 0..255 with ld_valid held high
  task automatic test_load(input int base);
    logic [22:0] d;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 23'(base);
    tick();
    for (int i = 0; i < 256; i++) begin
      d = 23'(base + i);
      bus.ld_data = d;
      checks++;
      if (bus.ld_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL load_ready beat %0d got %b want 1", i, bus.ld_ready);
      end
      model_mem[i / 4][33 * (i % 4) +: 33] = {1'b0, d, 9'd0};
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL load_return_idle busy=%b ld_ready=%b want 0/0", bus.busy, bus.ld_ready);
    end
    bus.ld_valid = 1'b0;
    tick();
  endtask

  // Full unload compared against the model; toggle=1 alternates ul_ready every cycle
  task automatic test_unload(input string name, input bit toggle);
    int          beat;
    int          cyc;
    bit          prev_stall;
    logic [22:0] held;
    logic [22:0] exp;
    beat = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    bus.ul_ready = 1'b1;
    bus.ul_start = 1'b1;
    tick();
    bus.ul_start = 1'b0;
    while (beat < 256 && cyc < 4000) begin
      if (toggle) bus.ul_ready = ((cyc % 2) == 1);
      if (prev_stall) begin
        checks++;
        if (bus.ul_valid !== 1'b1 || bus.ul_data !== held) begin
          failures++; $display("[TB] FAIL %s_stall_hold beat %0d got v=%b d=%0d want v=1 d=%0d", name, beat, bus.ul_valid, bus.ul_data, held);
        end
      end
      if (bus.ul_valid === 1'b1 && bus.ul_ready === 1'b1) begin
        exp = exp_coef(beat);
        checks++;
        if (bus.ul_data !== exp) begin
          failures++; $display("[TB] FAIL %s_data beat %0d got %0d want %0d", name, beat, bus.ul_data, exp);
        end
        checks++;
        if (bus.ul_last !== (beat == 255)) begin
          failures++; $display("[TB] FAIL %s_last beat %0d got %b want %b", name, beat, bus.ul_last, beat == 255);
        end
        got[beat] = bus.ul_data;
        beat++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = (bus.ul_valid === 1'b1);
        held = bus.ul_data;
      end
      tick();
      cyc++;
    end
    checks++;
    if (beat != 256) begin
      failures++; $display("[TB] FAIL %s_beats got %0d want 256", name, beat);
    end
    if (!toggle) begin
      checks++;
      if (cyc != 320) begin
        failures++; $display("[TB] FAIL %s_cycles got %0d want 320", name, cyc);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL %s_end_idle busy got %b want 0", name, bus.busy);
    end
    bus.ul_ready = 1'b0;
  endtask

  task automatic test_core_run();
    logic [131:0] old7;
    bus.mode_i = 3'd1; bus.go = 1'b1; bus.addra1 = 6'd0;
    tick();
    bus.go = 1'b0; bus.mode_i = 3'd0;
    checks++; if (bus.start !== 1'b1) begin failures++; $display("[TB] FAIL run_start_pulse got %b want 1", bus.start); end
    checks++; if (bus.busy !== 1'b1)  begin failures++; $display("[TB] FAIL run_busy got %b want 1", bus.busy); end
    checks++; if (bus.mode !== 3'd1)  begin failures++; $display("[TB] FAIL run_mode got %0d want 1", bus.mode); end
    tick();
    checks++; if (bus.start !== 1'b0) begin failures++; $display("[TB] FAIL run_start_width got %b want 0", bus.start); end
    checks++; if (bus.doa1 !== WORD0) begin failures++; $display("[TB] FAIL run_word0 got %0h want %0h", bus.doa1, WORD0); end
    old7 = model_mem[7];
    bus.addra1 = 6'd7; bus.addrb1 = 6'd7; bus.web1 = 1'b1; bus.dib1 = 132'h5;
    tick();
    bus.web1 = 1'b0;
    model_mem[7] = 132'h5;
    checks++; if (bus.doa1 !== old7)  begin failures++; $display("[TB] FAIL run_raw_old got %0h want %0h", bus.doa1, old7); end
    tick();
    checks++; if (bus.doa1 !== 132'h5) begin failures++; $display("[TB] FAIL run_raw_new got %0h want 5", bus.doa1); end
    checks++; if (bus.busy !== 1'b1 || bus.mode !== 3'd1) begin failures++; $display("[TB] FAIL run_hold busy=%b mode=%0d want 1/1", bus.busy, bus.mode); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++; if (bus.busy !== 1'b0)  begin failures++; $display("[TB] FAIL run_done_idle got %b want 0", bus.busy); end
    bus.addra1 = 6'd0;
    tick(); tick();
    checks++; if (bus.doa1 !== 132'h5) begin failures++; $display("[TB] FAIL idle_doa1_hold got %0h want 5", bus.doa1); end
  endtask

  task automatic test_idle_write();
    bus.web1 = 1'b1; bus.addrb1 = 6'd3; bus.dib1 = '1;
    tick(); tick(); tick();
    bus.web1 = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_write_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reduce();
    logic [131:0] w5;
    w5 = {1'b0, 23'd8388607, 9'h1FF, 1'b0, 23'd8380416, 9'h0AB,
          1'b0, 23'd8380417, 9'h001, 1'b0, 23'd8380418, 9'h155};
    bus.mode_i = 3'd1; bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    bus.web1 = 1'b1; bus.addrb1 = 6'd5; bus.dib1 = w5; bus.addra1 = 6'd5;
    tick();
    bus.web1 = 1'b0;
    model_mem[5] = w5;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    test_unload("reduce", 1'b0);
`ifdef COEF_REDUCE_EN
    checks++; if (got[20] !== 23'd1)    begin failures++; $display("[TB] FAIL reduce_q_plus_1 got %0d want 1", got[20]); end
    checks++; if (got[21] !== 23'd0)    begin failures++; $display("[TB] FAIL reduce_q got %0d want 0", got[21]); end
    checks++; if (got[23] !== 23'd8190) begin failures++; $display("[TB] FAIL reduce_max got %0d want 8190", got[23]); end
`else
    checks++; if (got[20] !== 23'd8380418) begin failures++; $display("[TB] FAIL raw_q_plus_1 got %0d want 8380418", got[20]); end
    checks++; if (got[21] !== 23'd8380417) begin failures++; $display("[TB] FAIL raw_q got %0d want 8380417", got[21]); end
    checks++; if (got[23] !== 23'd8388607) begin failures++; $display("[TB] FAIL raw_max got %0d want 8388607", got[23]); end
`endif
    checks++; if (got[22] !== 23'd8380416) begin failures++; $display("[TB] FAIL below_q got %0d want 8380416", got[22]); end
    checks++; if (got[12] !== 23'd12 || got[15] !== 23'd15) begin failures++; $display("[TB] FAIL idle_write_ignored got %0d/%0d want 12/15", got[12], got[15]); end
  endtask

  task automatic test_priority_reset();
    logic [22:0] d;
    bus.ld_valid = 1'b1; bus.go = 1'b1; bus.ul_start = 1'b1; bus.ld_data = 23'd1000;
    tick();
    bus.go = 1'b0; bus.ul_start = 1'b0;
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL prio_load got %b want 1", bus.ld_ready); end
    checks++; if (bus.start !== 1'b0)    begin failures++; $display("[TB] FAIL prio_no_start got %b want 0", bus.start); end
    checks++; if (bus.ul_valid !== 1'b0) begin failures++; $display("[TB] FAIL prio_no_unload got %b want 0", bus.ul_valid); end
    for (int i = 0; i < 130; i++) begin
      d = 23'(1000 + i);
      bus.ld_data = d;
      if (i < 128) model_mem[i / 4][33 * (i % 4) +: 33] = {1'b0, d, 9'd0};
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ld_ready !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_idle ld_ready=%b busy=%b want 0/0", bus.ld_ready, bus.busy); end
    checks++; if (bus.doa1 !== 132'd0) begin failures++; $display("[TB] FAIL midreset_doa1 got %0h want 0", bus.doa1); end
    checks++; if (bus.mode !== 3'd0)   begin failures++; $display("[TB] FAIL midreset_mode got %0d want 0", bus.mode); end
    bus.ld_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    test_unload("after_reset", 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.go = 1'b0; bus.mode_i = 3'd0; bus.done = 1'b0;
    bus.addra1 = '0; bus.web1 = 1'b0; bus.addrb1 = '0; bus.dib1 = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ul_start = 1'b0; bus.ul_ready = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    for (int i = 0; i < 256; i++) got[i] = '0;
    test_reset();
    test_load(0);
    test_unload("ul_ready_high", 1'b0);
    test_unload("ul_ready_toggle", 1'b1);
    test_core_run();
    test_idle_write();
    test_reduce();
    test_priority_reset();
    test_load(5000);
    test_unload("reload", 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
